// File: rtl/ice40_spram_arb_if.sv
// Request/response bundle for one requester port of ice40_spram_arb.
// The master side is the system requester, the slave side is the arbiter.
interface ice40_spram_arb_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = (DATA_WIDTH + 3) / 4
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [MASK_WIDTH-1:0] wmsk;
  logic                  we;
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (
    output addr, wdata, wmsk, we, valid,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  addr, wdata, wmsk, we, valid,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/ice40_spram_arb.sv
// Two-port SPRAM arbiter: port 0 has fixed priority, port 1 waits at most WAIT_MAX cycles.
// Registers the memory command and routes the 1-cycle SPRAM read data back to the issuing port.
module ice40_spram_arb #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = (DATA_WIDTH + 3) / 4,
  parameter int WAIT_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ice40_spram_arb_if.slave      p0,
  ice40_spram_arb_if.slave      p1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [MASK_WIDTH-1:0] mem_wr_mask,
  output logic                  mem_wr_ena,
  output logic                  mem_rd_ena,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  localparam int WCNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_MAX);

  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  wait_done;
  logic                  g0, g1;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [MASK_WIDTH-1:0] mem_wr_mask_q, mem_wr_mask_d;
  logic                  mem_wr_ena_q, mem_wr_ena_d;
  logic                  mem_rd_ena_q, mem_rd_ena_d;

  logic                  rd1_vld_q, rd1_vld_d, rd1_id_q, rd1_id_d;
  logic                  rd2_vld_q, rd2_id_q;

  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic                  p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;

  // With WAIT_MAX = 0 port 1 wins every conflict, so the counter never gates it.
  if (WAIT_MAX == 0) begin : g_nowait
    assign wait_done = 1'b1;
  end else begin : g_wait
    assign wait_done = (wcnt_q >= WCNT_MAX);
  end

  assign g1 = p1.valid & (~p0.valid | wait_done);
  assign g0 = p0.valid & ~g1;

  assign p0.ready = g0;
  assign p1.ready = g1;

  always_comb begin
    wcnt_d        = wcnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_mask_d = mem_wr_mask_q;
    mem_wr_ena_d  = 1'b0;
    mem_rd_ena_d  = 1'b0;
    rd1_vld_d     = 1'b0;
    rd1_id_d      = 1'b0;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    p0_rvalid_d   = 1'b0;
    p1_rvalid_d   = 1'b0;

    if (g1) begin
      wcnt_d = '0;
    end else if (p1.valid && g0 && (wcnt_q != WCNT_MAX)) begin
      wcnt_d = wcnt_q + 1'b1;
    end

    if (g0) begin
      mem_addr_d    = p0.addr;
      mem_wr_data_d = p0.wdata;
      mem_wr_mask_d = p0.wmsk;
      mem_wr_ena_d  = p0.we;
      mem_rd_ena_d  = ~p0.we;
      rd1_vld_d     = ~p0.we;
      rd1_id_d      = 1'b0;
    end else if (g1) begin
      mem_addr_d    = p1.addr;
      mem_wr_data_d = p1.wdata;
      mem_wr_mask_d = p1.wmsk;
      mem_wr_ena_d  = p1.we;
      mem_rd_ena_d  = ~p1.we;
      rd1_vld_d     = ~p1.we;
      rd1_id_d      = 1'b1;
    end

    // Stage 2 lines up with the cycle in which mem_rd_data is valid.
    if (rd2_vld_q) begin
      if (rd2_id_q) begin
        p1_rdata_d  = mem_rd_data;
        p1_rvalid_d = 1'b1;
      end else begin
        p0_rdata_d  = mem_rd_data;
        p0_rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q        <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_mask_q <= '0;
      mem_wr_ena_q  <= 1'b0;
      mem_rd_ena_q  <= 1'b0;
      rd1_vld_q     <= 1'b0;
      rd1_id_q      <= 1'b0;
      rd2_vld_q     <= 1'b0;
      rd2_id_q      <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
      p0_rvalid_q   <= 1'b0;
      p1_rvalid_q   <= 1'b0;
    end else begin
      wcnt_q        <= wcnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_mask_q <= mem_wr_mask_d;
      mem_wr_ena_q  <= mem_wr_ena_d;
      mem_rd_ena_q  <= mem_rd_ena_d;
      rd1_vld_q     <= rd1_vld_d;
      rd1_id_q      <= rd1_id_d;
      rd2_vld_q     <= rd1_vld_q;
      rd2_id_q      <= rd1_id_q;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
      p0_rvalid_q   <= p0_rvalid_d;
      p1_rvalid_q   <= p1_rvalid_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_mask = mem_wr_mask_q;
  assign mem_wr_ena  = mem_wr_ena_q;
  assign mem_rd_ena  = mem_rd_ena_q;
  assign p0.rdata    = p0_rdata_q;
  assign p1.rdata    = p1_rdata_q;
  assign p0.rvalid   = p0_rvalid_q;
  assign p1.rvalid   = p1_rvalid_q;
endmodule
